// File: rtl/uart_tx_fsm_if.sv
// Valid/ready word handshake between an upstream producer and the uart_tx_fsm sequencer.
// master = word producer, slave = transmitter.
interface uart_tx_fsm_if #(
  parameter int DATA_BITS = 8
);

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 busy;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  busy
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output busy
  );

endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: start bit, LSB-first data, optional even parity, one stop bit,
// each bit timed by an external bit-period counter. Parity enabled by `define UART_TX_PARITY_EN.
module uart_tx_fsm #(
  parameter int WIDTH        = 16,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fsm_if.slave     tx_if,
  output logic             cnt_en,
  output logic             cnt_clr,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             txd
);

  localparam int                 IDX_W    = $clog2(DATA_BITS);
  localparam logic [WIDTH-1:0]   LAST_CNT = WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               r_state;
  logic                 r_txd;
  logic [DATA_BITS-1:0] r_shreg;
  logic [IDX_W-1:0]     r_bitIdx;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_idle;
  logic w_bitDone;

  // A count at or beyond the last tick ends the bit, so an overrun never stalls the frame.
  assign w_idle    = (r_state == IDLE);
  assign w_bitDone = !w_idle && (cnt_value >= LAST_CNT);

  assign cnt_en         = !w_idle;
  assign cnt_clr        = w_idle | w_bitDone;
  assign tx_if.tx_ready = w_idle;
  assign tx_if.busy     = !w_idle;
  assign txd            = r_txd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_txd    <= 1'b1;
      r_shreg  <= '0;
      r_bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_if.tx_valid) begin
            r_shreg  <= tx_if.tx_data;
            r_state  <= START;
            r_txd    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^tx_if.tx_data;
`endif
          end
        end
        START: begin
          if (w_bitDone) begin
            r_state  <= DATA;
            r_txd    <= r_shreg[0];
            r_bitIdx <= '0;
          end
        end
        DATA: begin
          if (w_bitDone) begin
            r_shreg <= r_shreg >> 1;
            if (r_bitIdx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_parity;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_txd    <= r_shreg[1];
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bitDone) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          r_txd <= 1'b1;
          if (w_bitDone) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a bit-period counter model attached
// (CLKS_PER_BIT=4, DATA_BITS=8); honours `define UART_TX_PARITY_EN.
module tb_uart_tx_fsm;

  localparam int CPB   = 4;
  localparam int DBITS = 8;
  localparam int CW    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBITS + 3;
`else
  localparam int NB = DBITS + 2;
`endif
  localparam int F = NB * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cntEn;
  logic          cntClr;
  logic [CW-1:0] cntValue;
  logic          txd;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int lastAccept = 0;
  bit lastHeld = 1'b0;

  uart_tx_fsm_if #(.DATA_BITS(DBITS)) ifc ();

  uart_tx_fsm #(
    .WIDTH(CW),
    .DATA_BITS(DBITS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_if(ifc),
    .cnt_en(cntEn),
    .cnt_clr(cntClr),
    .cnt_value(cntValue),
    .txd(txd)
  );

  always #5 clk = ~clk;

  // Attached bit-period counter: clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cntValue <= '0;
    else if (cntClr) cntValue <= '0;
    else if (cntEn) cntValue <= cntValue + 16'd1;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference line value for bit position idx of a frame carrying word w.
  function automatic logic expBit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DBITS) return w[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == DBITS + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("idle_txd", 32'(txd), 32'd1);
      checkOutput("idle_ready", 32'(ifc.tx_ready), 32'd1);
      checkOutput("idle_clr", 32'(cntClr), 32'd1);
      @(negedge clk);
    end
  endtask

  // Offers word at a negedge with the block idle, then checks every cycle of the frame.
  task automatic applyStimulus(input logic [7:0] word, input logic [7:0] nextWord,
                               input bit holdNext, input int injectAt);
    int clrCount;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = word;
    @(negedge clk);
    if (lastHeld) checkOutput("b2b_spacing", cycleCount - lastAccept, F + 1);
    lastAccept = cycleCount;
    lastHeld   = holdNext;
    if (holdNext) begin
      ifc.tx_data = nextWord;
    end else begin
      ifc.tx_valid = 1'b0;
      ifc.tx_data  = 8'($urandom);
    end
    clrCount = 0;
    for (int c = 0; c < F; c++) begin
      if (!holdNext && c == injectAt) begin
        ifc.tx_valid = 1'b1;
        ifc.tx_data  = 8'hFF;
      end else if (!holdNext && c == injectAt + 1) begin
        ifc.tx_valid = 1'b0;
      end
      checkOutput($sformatf("txd_w%02h_c%0d", word, c), 32'(txd), 32'(expBit(word, c / CPB)));
      checkOutput($sformatf("ready_c%0d", c), 32'(ifc.tx_ready), 32'd0);
      checkOutput($sformatf("busy_c%0d", c), 32'(ifc.busy), 32'd1);
      checkOutput($sformatf("cnt_phase_c%0d", c), 32'(cntValue), 32'(c % CPB));
      if (cntClr) clrCount++;
      @(negedge clk);
    end
    checkOutput("clr_pulses", clrCount, NB);
    checkOutput("end_ready", 32'(ifc.tx_ready), 32'd1);
    checkOutput("end_txd", 32'(txd), 32'd1);
  endtask

  initial begin
    logic [7:0] word;
    logic [7:0] next;
    bit         hold;
    int         inj;

    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    reset        = 1'b1;
    @(negedge clk);
    ifc.tx_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_ready", 32'(ifc.tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(ifc.busy), 32'd0);
    checkOutput("rst_cnt_en", 32'(cntEn), 32'd0);
    checkOutput("rst_cnt_clr", 32'(cntClr), 32'd1);
    ifc.tx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    idleCycles(2);

    $display("[TB] single word 0xA5");
    applyStimulus(8'hA5, 8'h00, 1'b0, -1);
    idleCycles(1);

    $display("[TB] back-to-back 0x3C then 0x81 with valid held");
    applyStimulus(8'h3C, 8'h81, 1'b1, -1);
    applyStimulus(8'h81, 8'h00, 1'b0, -1);
    idleCycles(1);

    $display("[TB] valid pulse with 0xFF mid-frame");
    applyStimulus(8'h5A, 8'h00, 1'b0, 10);
    idleCycles(2);

    $display("[TB] word 0x07");
    applyStimulus(8'h07, 8'h00, 1'b0, -1);

    $display("[TB] reset mid-frame");
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'hC3;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_txd", 32'(txd), 32'd1);
    checkOutput("abort_ready", 32'(ifc.tx_ready), 32'd1);
    checkOutput("abort_cnt_clr", 32'(cntClr), 32'd1);
    checkOutput("abort_busy", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lastHeld = 1'b0;
    @(negedge clk);
    idleCycles(1);
    applyStimulus(8'h96, 8'h00, 1'b0, -1);
    idleCycles(1);

    $display("[TB] randomized words");
    word = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      next = 8'($urandom);
      hold = (k < 9) && ($urandom_range(0, 1) == 1);
      inj  = hold ? -1 : int'($urandom_range(1, F - 2));
      applyStimulus(word, next, hold, inj);
      word = next;
      if (!hold) idleCycles(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
